// File: rtl/mu0_mem_sys.sv
// Memory subsystem for the mu0 core: 4K x 16 RAM plus an I/O page holding a
// TX FIFO to the host, a one-word RX latch from the host and a status word.
module mu0_mem_sys #(
  parameter logic [11:0] IO_BASE  = 12'hFF0,
  parameter int          TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] addr,
  inout  wire  [15:0] data,
  input  logic        memrq,
  input  logic        rnw,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [11:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [15:0]   ram  [0:4095];
  logic [15:0]   fifo [0:TX_DEPTH-1];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] tx_cnt;
  logic          ovf, rx_full;
  logic [15:0]   rx_word;

  logic          io_sel, load_io;
  logic [3:0]    off;
  logic          rd_req, wr_req;
  logic          tx_push, tx_pop, push_ok, tx_full, tx_empty;
  logic          status_wr, rx_clear;
  logic [15:0]   status, rd_word;

  function automatic logic in_io(input logic [11:0] a);
    return ({1'b0, a} >= {1'b0, IO_BASE}) && ({1'b0, a} < ({1'b0, IO_BASE} + 13'd16));
  endfunction

  assign io_sel  = in_io(addr);
  assign load_io = in_io(load_addr);
  // Offset within the page is addr - IO_BASE; only the low nibble matters.
  assign off     = addr[3:0] - IO_BASE[3:0];

  assign rd_req    = memrq & rnw;
  assign wr_req    = memrq & ~rnw & ~load_en;
  assign tx_full   = (tx_cnt == CW'(TX_DEPTH));
  assign tx_empty  = (tx_cnt == '0);
  assign tx_pop    = ~tx_empty & tx_ready;
  assign tx_push   = wr_req & io_sel & (off == 4'd0) & ~reset;
  assign push_ok   = tx_push & (~tx_full | tx_pop);
  assign status_wr = wr_req & io_sel & (off == 4'd1);
  assign rx_clear  = rd_req & io_sel & (off == 4'd2) & rx_full;

  assign status   = {ovf, rx_full, tx_full, tx_empty, 8'h00, 4'(tx_cnt)};
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 16'h0000 : fifo[rd_ptr];
  assign rx_ready = ~rx_full;

  always_comb begin
    rd_word = 16'h0000;
    if (io_sel) begin
      case (off)
        4'd1:    rd_word = status;
        4'd2:    rd_word = rx_word;
        default: rd_word = 16'h0000;
      endcase
    end else begin
      rd_word = ram[addr];
    end
  end

  assign data = rd_req ? rd_word : 16'hzzzz;

  // RAM is never reset so preloaded code survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_req && !io_sel)
      ram[addr] <= data;
    if (load_en && load_we && !load_io)
      ram[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      tx_cnt  <= '0;
      ovf     <= 1'b0;
      rx_full <= 1'b0;
      rx_word <= 16'h0000;
    end else begin
      if (tx_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !tx_pop)
        tx_cnt <= tx_cnt + 1'b1;
      else if (!push_ok && tx_pop)
        tx_cnt <= tx_cnt - 1'b1;

      if (status_wr)
        ovf <= 1'b0;
      else if (tx_push && !push_ok)
        ovf <= 1'b1;

      if (rx_valid && !rx_full) begin
        rx_word <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_clear) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule
